// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the round datapath.
// Contents: data widths, round count, initial round constant, FSM encoding,
// and xtime(), the GF(2^8) doubling that mixColumns also uses.
package aes_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned KEY_W         = 128;
  localparam int unsigned IDX_W         = 4;
  localparam int unsigned AES128_ROUNDS = 10;

  localparam logic [BYTE_W-1:0] RCON_INIT = 8'h01;

  // Key-schedule FSM encoding
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } ks_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte).
// Ports:
//   byte_val  in  8  byte to substitute
//   sbox_c    out 8  S-box image of byte_val (combinational)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_val,
  output logic [BYTE_W-1:0] sbox_c
);

  // Entry b lives at bits [(255-b)*8 +: 8]; row r holds entries 16r..16r+15
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~b == 255-b for an 8-bit value, so this is the bit offset of entry b
  logic [10:0] offset;

  always_comb begin
    offset = {~byte_val, 3'b000};
    sbox_c = SBOX_TABLE[offset +: 8];
  end

endmodule

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128 key expansion: emits round keys 0..LAST_ROUND, one per
// valid/ready transfer, from a single registered 128-bit key state.
// Byte order: column c at [127-32c -: 32], row 0 is the MSB of a column.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   key_in    cipher key, sampled only when start is accepted in IDLE
//   start     begin a new expansion (ignored while busy)
//   busy      expansion in progress
//   rk_valid  rk_out/rk_idx hold a round key
//   rk_ready  consumer accepts the current round key
//   rk_out    round key rk_idx, w[4i] in [127:96]
//   rk_idx    round index of rk_out
//   done      one-cycle pulse after the final key transfers
module aes_key_schedule_iter
  import aes_pkg::*;
#(
  parameter int unsigned LAST_ROUND = AES128_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             start,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic [IDX_W-1:0] rk_idx,
  output logic             done
);

  ks_state_e         state, state_nxt;
  logic [BYTE_W-1:0] rcon, rcon_nxt;
  logic [KEY_W-1:0]  rk_out_nxt;
  logic [IDX_W-1:0]  rk_idx_nxt;
  logic              rk_valid_nxt, busy_nxt, done_nxt;

  // Expansion network driven straight from the registered key
  logic [WORD_W-1:0] w0, w1, w2, w3, rot, sub, t;
  logic [WORD_W-1:0] e0, e1, e2, e3;
  logic [KEY_W-1:0]  expanded_c;

  assign {w0, w1, w2, w3} = rk_out;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .byte_val (rot[i*BYTE_W +: BYTE_W]),
      .sbox_c   (sub[i*BYTE_W +: BYTE_W])
    );
  end

  always_comb begin
    t  = sub ^ {rcon, 24'h000000};
    e0 = w0 ^ t;
    e1 = w1 ^ e0;
    e2 = w2 ^ e1;
    e3 = w3 ^ e2;
    expanded_c = {e0, e1, e2, e3};
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    rcon_nxt     = rcon;
    rk_out_nxt   = rk_out;
    rk_idx_nxt   = rk_idx;
    rk_valid_nxt = rk_valid;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rk_out_nxt   = key_in;
          rk_idx_nxt   = '0;
          rcon_nxt     = RCON_INIT;
          rk_valid_nxt = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (rk_idx == IDX_W'(LAST_ROUND)) begin
            // Final key taken: key and index stay on the bus for inspection
            rk_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            state_nxt    = IDLE;
          end else begin
            rk_out_nxt = expanded_c;
            rk_idx_nxt = rk_idx + IDX_W'(1);
            rcon_nxt   = xtime(rcon);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rcon     <= RCON_INIT;
      rk_out   <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rcon     <= rcon_nxt;
      rk_out   <= rk_out_nxt;
      rk_idx   <= rk_idx_nxt;
      rk_valid <= rk_valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule
